ecc_rd_ctrl: RTL and testbench

Read-side initiator and SECDED decoder for the 1024x32 ECC SRAM macro.
- Accepts read requests on a valid/ready port and drives the macro read port (A1/CSB1/OEB1; CE1 tied to clk at top level).
- Captures O1, corrects single-bit errors and flags double-bit errors on the (32,26) codeword.
- Returns results on a valid/ready response port. It is the decode-side counterpart of the write path that stores encoded words through port 2.

---
 rtl/ecc_pkg.sv | 29 ++
 rtl/secded_dec_32_26.sv | 19 +
 rtl/ecc_rd_ctrl.sv | 90 +++++++++
 tb/tb_ecc_rd_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared (32,26) SECDED constants, bit map and syndrome helpers.
// Used by the read-side decoder and the write-side encoder.
package ecc_pkg;
  localparam int CW = 32;
  localparam int DW = 26;
  localparam logic [4:0] CHK_POS [5] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
  localparam logic [4:0] DATA_POS [DW] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
    5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
  // {overall parity, syndrome}; syndrome is the XOR of the Hamming indices of set bits 0..30
  function automatic logic [5:0] syn_par(input logic [CW-1:0] w);
    logic [4:0] s;
    s = '0;
    for (int p = 1; p < CW; p++) if (w[p-1]) s ^= 5'(p);
    return {^w, s};
  endfunction
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] w;
    logic [4:0] s;
    w = '0;
    for (int i = 0; i < DW; i++) w[DATA_POS[i] - 5'd1] = d[i];
    s = syn_par(w) [4:0];
    // each check position contributes to exactly one syndrome bit
    for (int k = 0; k < 5; k++) w[CHK_POS[k] - 5'd1] = s[k];
    w[CW-1] = ^w[CW-2:0];
    return w;
  endfunction
endpackage

// File: rtl/secded_dec_32_26.sv
// secded_dec_32_26: combinational SECDED decoder for the (32,26) codeword.
// i_word: codeword; o_data: corrected (raw on DED) data; o_sec/o_ded: error flags.
module secded_dec_32_26
  import ecc_pkg::*;
(
  input  logic [CW-1:0] i_word,
  output logic [DW-1:0] o_data,
  output logic          o_sec,
  output logic          o_ded
);
  logic [5:0] w_sp;
  assign w_sp = syn_par(i_word);
  assign o_sec = w_sp[5];
  assign o_ded = ~w_sp[5] & (|w_sp[4:0]);
  // a data bit flips only when odd parity points its syndrome at it; s=0 means bit 31
  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign o_data[i] = i_word[DATA_POS[i] - 5'd1] ^ (w_sp[5] && (w_sp[4:0] == DATA_POS[i]));
  end
endmodule

// File: rtl/ecc_rd_ctrl.sv
// ecc_rd_ctrl: read initiator + SECDED decode for the 1024x32 ECC SRAM port 1.
// Request port req_valid/req_ready/req_addr drives A1/CSB1/OEB1; O1 is decoded
// into the rsp_valid/rsp_ready response register (rsp_data/addr/sec/ded).
// ECC_ERR_CNT_EN enables saturating sec_cnt/ded_cnt with err_clr; otherwise tied to 0.
module ecc_rd_ctrl
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] A1,
  output logic              CSB1,
  output logic              OEB1,
  input  logic [CW-1:0]     O1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_sec,
  output logic              rsp_ded,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);
  logic              r_pend, r_full, r_sec, r_ded;
  logic [ADDR_W-1:0] r_pend_addr, r_addr;
  logic [DW-1:0]     r_data, w_data;
  logic              w_sec, w_ded, w_acc, w_load;
  secded_dec_32_26 u_dec (.i_word(O1), .o_data(w_data), .o_sec(w_sec), .o_ded(w_ded));
  assign req_ready = ~rst & (~r_full | rsp_ready);
  assign w_acc     = req_valid & req_ready;
  // select is combinational so the macro samples on the accepting edge
  assign CSB1      = ~w_acc;
  assign A1        = req_addr;
  assign OEB1      = 1'b0;
  assign w_load    = r_pend & (~r_full | rsp_ready);
  assign rsp_valid = r_full;
  assign rsp_data  = r_data;
  assign rsp_addr  = r_addr;
  assign rsp_sec   = r_sec;
  assign rsp_ded   = r_ded;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_full      <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_sec       <= 1'b0;
      r_ded       <= 1'b0;
    end else begin
      if (w_load) begin
        r_full <= 1'b1;
        r_data <= w_data;
        r_addr <= r_pend_addr;
        r_sec  <= w_sec;
        r_ded  <= w_ded;
      end else if (r_full & rsp_ready) r_full <= 1'b0;
      // while stalled in PEND_FULL no read issues, so O1 keeps the pending word
      if (w_acc) begin
        r_pend      <= 1'b1;
        r_pend_addr <= req_addr;
      end else if (w_load) r_pend <= 1'b0;
    end
  end
`ifdef ECC_ERR_CNT_EN
  logic [CNT_W-1:0] r_sec_cnt, r_ded_cnt;
  always_ff @(posedge clk) begin
    if (rst | err_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_load) begin
      if (w_sec && !(&r_sec_cnt)) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      if (w_ded && !(&r_ded_cnt)) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
    end
  end
  assign sec_cnt = r_sec_cnt;
  assign ded_cnt = r_ded_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif
endmodule

// File: tb/tb_ecc_rd_ctrl.sv
// tb_ecc_rd_ctrl: randomized self-checking bench for ecc_rd_ctrl with an SRAM model.
module tb_ecc_rd_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, CSB1, OEB1, rsp_valid, rsp_ready = 1'b0;
  logic        rsp_sec, rsp_ded, err_clr = 1'b0;
  logic [9:0]  req_addr = '0, A1, rsp_addr;
  logic [31:0] O1 = '0;
  logic [25:0] rsp_data;
  logic [15:0] sec_cnt, ded_cnt;
  ecc_rd_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .A1(A1), .CSB1(CSB1), .OEB1(OEB1), .O1(O1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_sec(rsp_sec), .rsp_ded(rsp_ded),
    .err_clr(err_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, n_acc = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  // SRAM macro model: sampled on the select edge, data appears after clock-to-out
  logic [31:0] mem [1024];
  logic [25:0] exp_d [1024];
  logic        exp_s [1024], exp_e [1024];
  always @(posedge clk) if (!CSB1) O1 <= #1 mem[A1];
  // Hamming reference: data fills non-power-of-two positions, check bits zero each syndrome bit
  function automatic logic [31:0] enc(input logic [25:0] d);
    logic [31:0] w;
    int i;
    logic par;
    w = '0;
    i = 0;
    for (int p = 1; p < 32; p++) if ((p & (p - 1)) != 0) begin w[p-1] = d[i]; i++; end
    for (int k = 0; k < 5; k++) begin
      par = 1'b0;
      for (int p = 1; p < 32; p++) if (((p >> k) & 1) == 1 && p != (1 << k)) par ^= w[p-1];
      w[(1 << k) - 1] = par;
    end
    w[31] = ^w[30:0];
    return w;
  endfunction
  function automatic logic [25:0] ext(input logic [31:0] w);
    logic [25:0] d;
    int i;
    d = '0;
    i = 0;
    for (int p = 1; p < 32; p++) if ((p & (p - 1)) != 0) begin d[i] = w[p-1]; i++; end
    return d;
  endfunction
  task automatic put(input int a, input logic [31:0] w, input logic [25:0] d, input logic s, input logic e);
    mem[a] = w;
    exp_d[a] = d;
    exp_s[a] = s;
    exp_e[a] = e;
  endtask
  // stores a random codeword with nf distinct flipped bits (0 clean, 1 SEC, 2 DED)
  task automatic put_rand(input int a, input int nf);
    logic [25:0] d;
    logic [31:0] w;
    int b1, b2;
    d = 26'($urandom);
    w = enc(d);
    b1 = $urandom_range(0, 31);
    b2 = (b1 + $urandom_range(1, 31)) % 32;
    if (nf >= 1) w[b1] = ~w[b1];
    if (nf == 2) w[b2] = ~w[b2];
    put(a, w, (nf == 2) ? ext(w) : d, nf == 1, nf == 2);
  endtask
  typedef struct { logic [9:0] a; logic [25:0] d; logic s; logic e; } exp_t;
  exp_t q[$];
  exp_t m_e;
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          m_e = q.pop_front();
          check("rsp_addr", 32'(rsp_addr), 32'(m_e.a));
          check("rsp_data", 32'(rsp_data), 32'(m_e.d));
          check("rsp_sec", 32'(rsp_sec), 32'(m_e.s));
          check("rsp_ded", 32'(rsp_ded), 32'(m_e.e));
        end
      end
      if (req_valid && req_ready) begin
        q.push_back('{a: req_addr, d: exp_d[req_addr], s: exp_s[req_addr], e: exp_e[req_addr]});
        n_acc++;
      end
    end
  end
  task automatic issue(input logic [9:0] a);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) check("req_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((q.size() != 0 || rsp_valid) && t < 300) begin @(negedge clk); t++; end
    if (q.size() != 0 || rsp_valid) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  bit done = 0;
  int base;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int a = 0; a < 1024; a++) put_rand(a, $urandom_range(0, 2));
    req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_csb", 32'(CSB1), 1);
    end
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_addr", 32'(rsp_addr), 0);
    check("rst_flags", {rsp_sec, rsp_ded}, 0);
    check("rst_cnt", {sec_cnt, ded_cnt}, 0);
    check("oeb", 32'(OEB1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    put(5, 32'hFFFF_FFFF, 26'h3FF_FFFF, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_addr = 10'h005;
    @(negedge clk);
    check("t1_req_ready", 32'(req_ready), 1);
    check("t1_csb", 32'(CSB1), 0);
    check("t1_a1", 32'(A1), 32'h5);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("t1_lat_pend", 32'(rsp_valid), 0);
    @(negedge clk);
    check("t1_lat_valid", 32'(rsp_valid), 1);
    drain();
    put(10'h20, 32'h0000_0004, 26'h0, 1'b1, 1'b0);
    put(10'h21, 32'h8000_0000, 26'h0, 1'b1, 1'b0);
    put(10'h22, 32'h0000_0001, 26'h0, 1'b1, 1'b0);
    put(10'h23, 32'h0000_0006, 26'h1, 1'b0, 1'b1);
    put(10'h24, 32'h0000_0003, 26'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) issue(10'(10'h20 + i));
    drain();
`ifndef ECC_ERR_CNT_EN
    check("cnt_tied_sec", 32'(sec_cnt), 0);
    check("cnt_tied_ded", 32'(ded_cnt), 0);
`endif
    rsp_ready = 1'b0;
    base = n_acc;
    fork
      begin
        issue(0);
        issue(1);
        issue(2);
      end
      begin
        repeat (3) @(negedge clk);
        check("t4_csb_stall", 32'(CSB1), 1);
        @(negedge clk);
        check("t4_accepts", n_acc - base, 2);
        check("t4_req_ready", 32'(req_ready), 0);
        check("t4_rsp_valid", 32'(rsp_valid), 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();
    check("t4_in_order", n_acc - base, 3);
    issue(7);
    rst = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    check("t5_req_ready", 32'(req_ready), 0);
    check("t5_csb", 32'(CSB1), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_rsp", 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
`ifdef ECC_ERR_CNT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    for (int i = 0; i < 5; i++) put_rand(10'h30 + i, (i < 3) ? 1 : 2);
    for (int i = 0; i < 5; i++) issue(10'(10'h30 + i));
    drain();
    check("cnt_sec3", 32'(sec_cnt), 3);
    check("cnt_ded2", 32'(ded_cnt), 2);
    put_rand(10'h35, 1);
    issue(10'h35);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    drain();
    check("cnt_clr_sec", 32'(sec_cnt), 0);
    check("cnt_clr_ded", 32'(ded_cnt), 0);
    force dut.r_sec_cnt = 16'hFFFF;
    #1 release dut.r_sec_cnt;
    issue(10'h35);
    drain();
    check("cnt_sat", 32'(sec_cnt), 32'hFFFF);
`endif
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          issue(10'($urandom_range(0, 1023)));
        end
        drain();
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    rsp_ready = 1'b1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
